serv_ibus_prefetch: RTL and testbench



---
 rtl/serv_ibus_prefetch.sv | 233 +++++++++++++++++++++++
 tb/tb_serv_ibus_prefetch.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_ibus_prefetch.sv
// ============================================================================
// serv_ibus_prefetch
// ----------------------------------------------------------------------------
// Single-entry instruction prefetch buffer. It sits between the core's
// instruction-bus request port and the external Wishbone instruction bus.
// After the instruction at address A is delivered, the block speculatively
// fetches A+4. If the core then asks for A+4 sequentially, the request is
// answered in one cycle. A non-sequential request (jump, trap) waits for the
// outstanding speculative access to finish, throws its data away and then
// issues a demand fetch.
//
// Parameters
//   PREFETCH   1: speculative fetch of A+4 enabled
//              0: registered pass-through, demand fetches only
//
// Ports
//   clk         clock, all state updates on the rising edge
//   i_rst_n     asynchronous active-low reset
//   i_cpu_cyc   core fetch request, held high until o_cpu_ack
//   i_cpu_adr   fetch address (word aligned, stable while i_cpu_cyc is high)
//   o_cpu_ack   single-cycle pulse, o_cpu_rdt valid (decoder fetch enable)
//   o_cpu_rdt   instruction word, held until the next ack
//   i_inv       invalidate the buffer (fence.i / trap entry)
//   o_wb_cyc    Wishbone cycle/strobe
//   o_wb_adr    Wishbone address
//   i_wb_rdt    Wishbone read data
//   i_wb_ack    Wishbone acknowledge (ignored while o_wb_cyc is low)
// ============================================================================
module serv_ibus_prefetch #(
    parameter bit PREFETCH = 1'b1
) (
    input  logic        clk,
    input  logic        i_rst_n,
    // core side
    input  logic        i_cpu_cyc,
    input  logic [31:0] i_cpu_adr,
    output logic        o_cpu_ack,
    output logic [31:0] o_cpu_rdt,
    input  logic        i_inv,
    // Wishbone side
    output logic        o_wb_cyc,
    output logic [31:0] o_wb_adr,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack
);

    // IDLE   : no bus cycle, the buffer may hold the next instruction
    // DEMAND : bus cycle on behalf of a waiting core request
    // SPEC   : speculative fetch of the word after the last delivered one
    // STALE  : speculative fetch still in flight but no longer wanted;
    //          its data is dropped and a demand fetch follows
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DEMAND = 2'd1,
        ST_SPEC   = 2'd2,
        ST_STALE  = 2'd3
    } state_t;

    state_t      state_q,     state_d;
    logic        wb_cyc_q,    wb_cyc_d;
    logic [31:0] wb_adr_q,    wb_adr_d;
    logic        cpu_ack_q,   cpu_ack_d;
    logic [31:0] cpu_rdt_q,   cpu_rdt_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_adr_q,   buf_adr_d;
    logic [31:0] buf_data_q,  buf_data_d;
    // Set when an invalidate hits while a speculative fetch is in flight and
    // no request is waiting; the returning data must not be used.
    logic        spec_inv_q,  spec_inv_d;

    // The core only drops cyc combinationally on our ack, so the request
    // line is still high during the ack cycle. Masking it here prevents the
    // same request from being served twice.
    logic        cpu_req;
    logic [31:0] wb_adr_inc;
    logic [31:0] buf_adr_inc;
    logic        buf_hit;
    logic        spec_stale;
    logic        spec_match;

    assign cpu_req     = i_cpu_cyc & ~cpu_ack_q;
    // Plain 32-bit addition: 0xFFFFFFFC + 4 wraps to 0.
    assign wb_adr_inc  = wb_adr_q + 32'd4;
    assign buf_adr_inc = buf_adr_q + 32'd4;

    // An invalidate in the same cycle overrides a hit.
    assign buf_hit     = cpu_req & buf_valid_q & (i_cpu_adr == buf_adr_q) & ~i_inv;

    // The in-flight speculative word is usable only if nothing invalidated
    // it since it was issued (including this cycle).
    assign spec_stale  = spec_inv_q | i_inv;
    assign spec_match  = cpu_req & (i_cpu_adr == wb_adr_q) & ~spec_stale;

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        wb_cyc_d    = wb_cyc_q;
        wb_adr_d    = wb_adr_q;
        cpu_ack_d   = 1'b0;
        cpu_rdt_d   = cpu_rdt_q;
        buf_valid_d = buf_valid_q;
        buf_adr_d   = buf_adr_q;
        buf_data_d  = buf_data_q;
        spec_inv_d  = spec_inv_q;

        if (i_inv) begin
            buf_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                spec_inv_d = 1'b0;
                if (cpu_req) begin
                    if (buf_hit) begin
                        cpu_ack_d   = 1'b1;
                        cpu_rdt_d   = buf_data_q;
                        buf_valid_d = 1'b0;
                        if (PREFETCH) begin
                            state_d  = ST_SPEC;
                            wb_cyc_d = 1'b1;
                            wb_adr_d = buf_adr_inc;
                        end
                    end else begin
                        state_d     = ST_DEMAND;
                        wb_cyc_d    = 1'b1;
                        wb_adr_d    = i_cpu_adr;
                        buf_valid_d = 1'b0;
                    end
                end
            end

            ST_DEMAND: begin
                if (i_wb_ack) begin
                    cpu_ack_d = 1'b1;
                    cpu_rdt_d = i_wb_rdt;
                    if (PREFETCH) begin
                        // Keep cyc high and move straight on to the next word.
                        state_d    = ST_SPEC;
                        wb_adr_d   = wb_adr_inc;
                        spec_inv_d = 1'b0;
                    end else begin
                        state_d  = ST_IDLE;
                        wb_cyc_d = 1'b0;
                    end
                end
            end

            ST_SPEC: begin
                if (i_wb_ack) begin
                    spec_inv_d = 1'b0;
                    if (spec_match) begin
                        // Core already wants this word: forward it directly
                        // and chain the next speculative fetch.
                        cpu_ack_d = 1'b1;
                        cpu_rdt_d = i_wb_rdt;
                        wb_adr_d  = wb_adr_inc;
                    end else if (cpu_req) begin
                        // Wrong word (or invalidated): drop the data and
                        // re-address without releasing cyc.
                        state_d  = ST_DEMAND;
                        wb_adr_d = i_cpu_adr;
                    end else if (spec_stale) begin
                        state_d  = ST_IDLE;
                        wb_cyc_d = 1'b0;
                    end else begin
                        state_d     = ST_IDLE;
                        wb_cyc_d    = 1'b0;
                        buf_valid_d = 1'b1;
                        buf_adr_d   = wb_adr_q;
                        buf_data_d  = i_wb_rdt;
                    end
                end else if (cpu_req && !spec_match) begin
                    state_d = ST_STALE;
                end else if (i_inv) begin
                    spec_inv_d = 1'b1;
                end
            end

            ST_STALE: begin
                spec_inv_d = 1'b0;
                if (i_wb_ack) begin
                    if (cpu_req) begin
                        state_d  = ST_DEMAND;
                        wb_adr_d = i_cpu_adr;
                    end else begin
                        state_d  = ST_IDLE;
                        wb_cyc_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d  = ST_IDLE;
                wb_cyc_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            wb_cyc_q    <= 1'b0;
            wb_adr_q    <= 32'd0;
            cpu_ack_q   <= 1'b0;
            cpu_rdt_q   <= 32'd0;
            buf_valid_q <= 1'b0;
            buf_adr_q   <= 32'd0;
            buf_data_q  <= 32'd0;
            spec_inv_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wb_cyc_q    <= wb_cyc_d;
            wb_adr_q    <= wb_adr_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_rdt_q   <= cpu_rdt_d;
            buf_valid_q <= buf_valid_d;
            buf_adr_q   <= buf_adr_d;
            buf_data_q  <= buf_data_d;
            spec_inv_q  <= spec_inv_d;
        end
    end

    assign o_cpu_ack = cpu_ack_q;
    assign o_cpu_rdt = cpu_rdt_q;
    assign o_wb_cyc  = wb_cyc_q;
    assign o_wb_adr  = wb_adr_q;

endmodule

// File: tb/tb_serv_ibus_prefetch.sv
// ============================================================================
// tb_serv_ibus_prefetch
// ----------------------------------------------------------------------------
// Self-checking bench for serv_ibus_prefetch. Directed scenarios check exact
// cycle timing; a randomized phase drives a core model and a Wishbone memory
// model and checks that every request gets exactly one ack carrying the
// memory contents for its address, with memory "generations" changed only
// together with an invalidate.
// ============================================================================
module tb_serv_ibus_prefetch;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        cpu_cyc, cpu_ack, inv, wb_cyc, wb_ack;
    logic [31:0] cpu_adr, cpu_rdt, wb_adr, wb_rdt;

    logic        np_cpu_cyc, np_cpu_ack, np_inv, np_wb_cyc, np_wb_ack;
    logic [31:0] np_cpu_adr, np_cpu_rdt, np_wb_adr, np_wb_rdt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serv_ibus_prefetch #(.PREFETCH(1'b1)) dut (
        .clk       (clk),
        .i_rst_n   (rst_n),
        .i_cpu_cyc (cpu_cyc),
        .i_cpu_adr (cpu_adr),
        .o_cpu_ack (cpu_ack),
        .o_cpu_rdt (cpu_rdt),
        .i_inv     (inv),
        .o_wb_cyc  (wb_cyc),
        .o_wb_adr  (wb_adr),
        .i_wb_rdt  (wb_rdt),
        .i_wb_ack  (wb_ack)
    );

    serv_ibus_prefetch #(.PREFETCH(1'b0)) dut_np (
        .clk       (clk),
        .i_rst_n   (rst_n),
        .i_cpu_cyc (np_cpu_cyc),
        .i_cpu_adr (np_cpu_adr),
        .o_cpu_ack (np_cpu_ack),
        .o_cpu_rdt (np_cpu_rdt),
        .i_inv     (np_inv),
        .o_wb_cyc  (np_wb_cyc),
        .o_wb_adr  (np_wb_adr),
        .i_wb_rdt  (np_wb_rdt),
        .i_wb_ack  (np_wb_ack)
    );

    // Memory contents for the randomized phase.
    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] gen);
        return (a * 32'h9E3779B1) ^ 32'h13579BDF ^ (gen * 32'h01010101);
    endfunction

    task automatic clear_inputs();
        cpu_cyc = 1'b0; cpu_adr = 32'd0; inv = 1'b0; wb_ack = 1'b0; wb_rdt = 32'd0;
        np_cpu_cyc = 1'b0; np_cpu_adr = 32'd0; np_inv = 1'b0; np_wb_ack = 1'b0; np_wb_rdt = 32'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({cpu_ack, cpu_rdt, wb_cyc, wb_adr} !== 66'd0) begin
            errors++;
            $display("FAIL reset_values: ack=%0b rdt=%h cyc=%0b adr=%h, expected all zero", cpu_ack, cpu_rdt, wb_cyc, wb_adr);
        end
        checks++;
        if ({np_cpu_ack, np_cpu_rdt, np_wb_cyc, np_wb_adr} !== 66'd0) begin
            errors++;
            $display("FAIL reset_values_np: ack=%0b rdt=%h cyc=%0b adr=%h, expected all zero", np_cpu_ack, np_cpu_rdt, np_wb_cyc, np_wb_adr);
        end
        // reset in the middle of a demand fetch
        cpu_cyc = 1'b1; cpu_adr = 32'h40;
        @(negedge clk);
        checks++;
        if ({wb_cyc, wb_adr} !== {1'b1, 32'h40}) begin
            errors++;
            $display("FAIL reset_pre_demand: cyc=%0b adr=%h, expected 1 00000040", wb_cyc, wb_adr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cpu_ack, wb_cyc, wb_adr} !== 34'd0) begin
            errors++;
            $display("FAIL reset_async: ack=%0b cyc=%0b adr=%h, expected 0 0 0", cpu_ack, wb_cyc, wb_adr);
        end
        cpu_cyc = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cpu_cyc = 1'b1; cpu_adr = 32'h0;
        @(negedge clk);
        checks++;
        if ({wb_cyc, wb_adr, cpu_ack} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_fresh_cycle: cyc=%0b adr=%h ack=%0b, expected 1 00000000 0", wb_cyc, wb_adr, cpu_ack);
        end
        wb_ack = 1'b1; wb_rdt = 32'h11;
        @(negedge clk);
        checks++;
        if ({cpu_ack, cpu_rdt} !== {1'b1, 32'h11}) begin
            errors++;
            $display("FAIL reset_fresh_ack: ack=%0b rdt=%h, expected 1 00000011", cpu_ack, cpu_rdt);
        end
        $display("txn reset adr=00000000 rdt=%h", cpu_rdt);
        do_reset();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_sequential();
        cpu_cyc = 1'b1; cpu_adr = 32'h100;
        @(negedge clk);
        checks++;
        if ({wb_cyc, wb_adr, cpu_ack} !== {1'b1, 32'h100, 1'b0}) begin
            errors++;
            $display("FAIL seq_demand_issue: cyc=%0b adr=%h ack=%0b, expected 1 00000100 0", wb_cyc, wb_adr, cpu_ack);
        end
        @(negedge clk);
        wb_ack = 1'b1; wb_rdt = 32'h00000013;
        @(negedge clk);
        checks++;
        if ({cpu_ack, cpu_rdt} !== {1'b1, 32'h00000013}) begin
            errors++;
            $display("FAIL seq_demand_ack: ack=%0b rdt=%h, expected 1 00000013", cpu_ack, cpu_rdt);
        end
        checks++;
        if ({wb_cyc, wb_adr} !== {1'b1, 32'h104}) begin
            errors++;
            $display("FAIL seq_spec_issue: cyc=%0b adr=%h, expected 1 00000104", wb_cyc, wb_adr);
        end
        $display("txn seq adr=00000100 rdt=%h", cpu_rdt);
        cpu_cyc = 1'b0;
        wb_ack = 1'b1; wb_rdt = 32'h00A00093;
        @(negedge clk);
        checks++;
        if ({cpu_ack, wb_cyc} !== 2'b00) begin
            errors++;
            $display("FAIL seq_spec_fill: ack=%0b cyc=%0b, expected 0 0", cpu_ack, wb_cyc);
        end
        wb_ack = 1'b0;
        cpu_cyc = 1'b1; cpu_adr = 32'h104;
        @(negedge clk);
        checks++;
        if ({cpu_ack, cpu_rdt} !== {1'b1, 32'h00A00093}) begin
            errors++;
            $display("FAIL seq_hit: ack=%0b rdt=%h, expected 1 00a00093", cpu_ack, cpu_rdt);
        end
        checks++;
        if ({wb_cyc, wb_adr} !== {1'b1, 32'h108}) begin
            errors++;
            $display("FAIL seq_hit_spec: cyc=%0b adr=%h, expected 1 00000108", wb_cyc, wb_adr);
        end
        $display("txn seq adr=00000104 rdt=%h", cpu_rdt);
        cpu_cyc = 1'b0;
    endtask

    // Continues from test_sequential: speculative fetch of 0x108 in flight.
    task automatic test_jump();
        @(negedge clk);
        cpu_cyc = 1'b1; cpu_adr = 32'h200;
        @(negedge clk);
        checks++;
        if ({wb_cyc, wb_adr, cpu_ack} !== {1'b1, 32'h108, 1'b0}) begin
            errors++;
            $display("FAIL jump_wait_stale: cyc=%0b adr=%h ack=%0b, expected 1 00000108 0", wb_cyc, wb_adr, cpu_ack);
        end
        wb_ack = 1'b1; wb_rdt = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if ({wb_cyc, wb_adr, cpu_ack} !== {1'b1, 32'h200, 1'b0}) begin
            errors++;
            $display("FAIL jump_demand: cyc=%0b adr=%h ack=%0b, expected 1 00000200 0", wb_cyc, wb_adr, cpu_ack);
        end
        wb_ack = 1'b1; wb_rdt = 32'h00000297;
        @(negedge clk);
        checks++;
        if ({cpu_ack, cpu_rdt, wb_adr} !== {1'b1, 32'h00000297, 32'h204}) begin
            errors++;
            $display("FAIL jump_deliver: ack=%0b rdt=%h adr=%h, expected 1 00000297 00000204", cpu_ack, cpu_rdt, wb_adr);
        end
        $display("txn jump adr=00000200 rdt=%h", cpu_rdt);
        cpu_cyc = 1'b0; wb_ack = 1'b0;
    endtask

    // Continues from test_jump: speculative fetch of 0x204 in flight.
    task automatic test_spec_match();
        @(negedge clk);
        cpu_cyc = 1'b1; cpu_adr = 32'h204;
        wb_ack = 1'b1; wb_rdt = 32'h00B00113;
        @(negedge clk);
        checks++;
        if ({cpu_ack, cpu_rdt} !== {1'b1, 32'h00B00113}) begin
            errors++;
            $display("FAIL match_deliver: ack=%0b rdt=%h, expected 1 00b00113", cpu_ack, cpu_rdt);
        end
        checks++;
        if ({wb_cyc, wb_adr} !== {1'b1, 32'h208}) begin
            errors++;
            $display("FAIL match_next_spec: cyc=%0b adr=%h, expected 1 00000208", wb_cyc, wb_adr);
        end
        $display("txn match adr=00000204 rdt=%h", cpu_rdt);
        cpu_cyc = 1'b0; wb_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL match_single_ack: ack=%0b, expected 0", cpu_ack);
        end
        do_reset();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_inv();
        // fill the buffer with 0x10C
        cpu_cyc = 1'b1; cpu_adr = 32'h108;
        @(negedge clk);
        wb_ack = 1'b1; wb_rdt = 32'h1111_0108;
        @(negedge clk);
        cpu_cyc = 1'b0;
        wb_ack = 1'b1; wb_rdt = 32'h2222_010C;
        @(negedge clk);
        checks++;
        if (wb_cyc !== 1'b0) begin
            errors++;
            $display("FAIL inv_fill: cyc=%0b, expected 0", wb_cyc);
        end
        wb_ack = 1'b0; inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
        cpu_cyc = 1'b1; cpu_adr = 32'h10C;
        @(negedge clk);
        checks++;
        if ({wb_cyc, wb_adr, cpu_ack} !== {1'b1, 32'h10C, 1'b0}) begin
            errors++;
            $display("FAIL inv_miss: cyc=%0b adr=%h ack=%0b, expected 1 0000010c 0", wb_cyc, wb_adr, cpu_ack);
        end
        wb_ack = 1'b1; wb_rdt = 32'h3333_010C;
        @(negedge clk);
        checks++;
        if ({cpu_ack, cpu_rdt} !== {1'b1, 32'h3333_010C}) begin
            errors++;
            $display("FAIL inv_refetch: ack=%0b rdt=%h, expected 1 3333010c", cpu_ack, cpu_rdt);
        end
        $display("txn inv adr=0000010c rdt=%h", cpu_rdt);
        // fill 0x110, then invalidate in the same cycle as a would-be hit
        cpu_cyc = 1'b0;
        wb_ack = 1'b1; wb_rdt = 32'h4444_0110;
        @(negedge clk);
        wb_ack = 1'b0;
        cpu_cyc = 1'b1; cpu_adr = 32'h110; inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
        checks++;
        if ({wb_cyc, wb_adr, cpu_ack} !== {1'b1, 32'h110, 1'b0}) begin
            errors++;
            $display("FAIL inv_priority: cyc=%0b adr=%h ack=%0b, expected 1 00000110 0", wb_cyc, wb_adr, cpu_ack);
        end
        wb_ack = 1'b1; wb_rdt = 32'h5555_0110;
        @(negedge clk);
        checks++;
        if ({cpu_ack, cpu_rdt} !== {1'b1, 32'h5555_0110}) begin
            errors++;
            $display("FAIL inv_priority_data: ack=%0b rdt=%h, expected 1 55550110", cpu_ack, cpu_rdt);
        end
        $display("txn inv adr=00000110 rdt=%h", cpu_rdt);
        // invalidate while the speculative fetch of 0x114 is in flight
        cpu_cyc = 1'b0; wb_ack = 1'b0; inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
        wb_ack = 1'b1; wb_rdt = 32'h6666_0114;
        @(negedge clk);
        wb_ack = 1'b0;
        cpu_cyc = 1'b1; cpu_adr = 32'h114;
        @(negedge clk);
        checks++;
        if ({wb_cyc, wb_adr, cpu_ack} !== {1'b1, 32'h114, 1'b0}) begin
            errors++;
            $display("FAIL inv_spec_discard: cyc=%0b adr=%h ack=%0b, expected 1 00000114 0", wb_cyc, wb_adr, cpu_ack);
        end
        do_reset();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_wrap();
        cpu_cyc = 1'b1; cpu_adr = 32'hFFFF_FFFC;
        @(negedge clk);
        wb_ack = 1'b1; wb_rdt = 32'h7777_FFFC;
        @(negedge clk);
        checks++;
        if ({cpu_ack, cpu_rdt, wb_cyc, wb_adr} !== {1'b1, 32'h7777_FFFC, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL wrap_spec_adr: ack=%0b rdt=%h cyc=%0b adr=%h, expected 1 7777fffc 1 00000000", cpu_ack, cpu_rdt, wb_cyc, wb_adr);
        end
        $display("txn wrap adr=fffffffc rdt=%h", cpu_rdt);
        do_reset();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_no_prefetch();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = 32'h300 + 32'(i) * 32'd4;
            np_cpu_cyc = 1'b1; np_cpu_adr = a;
            @(negedge clk);
            checks++;
            if ({np_wb_cyc, np_wb_adr, np_cpu_ack} !== {1'b1, a, 1'b0}) begin
                errors++;
                $display("FAIL np_demand: cyc=%0b adr=%h ack=%0b, expected 1 %h 0", np_wb_cyc, np_wb_adr, np_cpu_ack, a);
            end
            np_wb_ack = 1'b1; np_wb_rdt = mem_word(a, 32'd0);
            @(negedge clk);
            checks++;
            if ({np_cpu_ack, np_cpu_rdt, np_wb_cyc} !== {1'b1, mem_word(a, 32'd0), 1'b0}) begin
                errors++;
                $display("FAIL np_ack: ack=%0b rdt=%h cyc=%0b, expected 1 %h 0", np_cpu_ack, np_cpu_rdt, np_wb_cyc, mem_word(a, 32'd0));
            end
            $display("txn np adr=%h rdt=%h", a, np_cpu_rdt);
            // a stray bus ack while idle must do nothing
            np_cpu_cyc = 1'b0;
            np_wb_ack = 1'b1; np_wb_rdt = 32'hBAD0_0000;
            @(negedge clk);
            np_wb_ack = 1'b0;
            checks++;
            if ({np_cpu_ack, np_wb_cyc} !== 2'b00) begin
                errors++;
                $display("FAIL np_idle_ack: ack=%0b cyc=%0b, expected 0 0", np_cpu_ack, np_wb_cyc);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_random(input int n_cycles);
        bit          outstanding = 1'b0;
        bit          have_last   = 1'b0;
        bit          acc_active  = 1'b0;
        int          acc_cnt     = 0;
        int          wait_cnt    = 0;
        int          n_txn       = 0;
        int          r;
        logic [31:0] gen      = 32'd0;
        logic [31:0] acc_gen  = 32'd0;
        logic [31:0] req_adr  = 32'd0;
        logic [31:0] last_adr = 32'h1000;
        logic [31:0] last_rdt = 32'd0;
        logic [31:0] exp_rdt;
        logic [31:0] a;

        do_reset();
        for (int cyc_i = 0; cyc_i < n_cycles + 200; cyc_i++) begin
            if (cyc_i >= n_cycles && !outstanding) break;
            @(negedge clk);

            // core side: observe
            if (cpu_ack) begin
                checks++;
                if (!outstanding) begin
                    errors++;
                    $display("FAIL rand_spurious_ack: ack=1 with no request pending, expected 0");
                end else begin
                    exp_rdt = mem_word(req_adr, gen);
                    if (cpu_rdt !== exp_rdt) begin
                        errors++;
                        $display("FAIL rand_data: adr=%h rdt=%h, expected %h", req_adr, cpu_rdt, exp_rdt);
                    end
                    $display("txn rand %0d adr=%h rdt=%h", n_txn, req_adr, cpu_rdt);
                    n_txn++;
                    last_rdt  = exp_rdt;
                    have_last = 1'b1;
                end
                outstanding = 1'b0;
                cpu_cyc     = 1'b0;
            end else begin
                if (have_last) begin
                    checks++;
                    if (cpu_rdt !== last_rdt) begin
                        errors++;
                        $display("FAIL rand_rdt_hold: rdt=%h, expected %h", cpu_rdt, last_rdt);
                    end
                end
                if (outstanding) begin
                    wait_cnt++;
                    if (wait_cnt > 64) begin
                        checks++;
                        errors++;
                        $display("FAIL rand_timeout: adr=%h no ack after %0d cycles, expected ack", req_adr, wait_cnt);
                        break;
                    end
                end
            end

            // Wishbone memory: data is taken from the generation current when
            // the access started
            if (wb_cyc) begin
                if (!acc_active) begin
                    acc_active = 1'b1;
                    acc_gen    = gen;
                    acc_cnt    = int'($urandom_range(0, 3));
                end
                if (acc_cnt == 0) begin
                    wb_ack     = 1'b1;
                    wb_rdt     = mem_word(wb_adr, acc_gen);
                    acc_active = 1'b0;
                end else begin
                    acc_cnt--;
                    wb_ack = 1'b0;
                    wb_rdt = $urandom;
                end
            end else begin
                acc_active = 1'b0;
                wb_ack     = ($urandom_range(0, 9) == 0);
                wb_rdt     = $urandom;
            end

            // core side: new request / code modification with invalidate
            inv = 1'b0;
            if (!outstanding && cyc_i < n_cycles) begin
                r = int'($urandom_range(0, 99));
                if (r < 4) begin
                    gen = gen + 32'd1;
                    inv = 1'b1;
                end else if (r < 60) begin
                    r = int'($urandom_range(0, 99));
                    if (r < 65)      a = last_adr + 32'd4;
                    else if (r < 80) a = last_adr;
                    else if (r < 95) a = 32'h1000 + 32'($urandom_range(0, 63)) * 32'd4;
                    else             a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
                    cpu_cyc     = 1'b1;
                    cpu_adr     = a;
                    req_adr     = a;
                    last_adr    = a;
                    outstanding = 1'b1;
                    wait_cnt    = 0;
                end
            end else if (outstanding && $urandom_range(0, 99) < 3) begin
                inv = 1'b1;
            end
        end
        do_reset();
    endtask

    // ------------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_sequential();
        test_jump();
        test_spec_match();
        test_inv();
        test_wrap();
        test_no_prefetch();
        test_random(4000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
